pingpong_framebuf: RTL and testbench
====================================

Name: pingpong_framebuf

Overview:
- Parametrised double-buffered pixel frame store between the ray-tracer host (writer) and the VGA scan-out (reader).
- The writer fills the back buffer while the reader scans the front buffer.
- Buffers swap only at a reader frame boundary after the writer has declared its frame complete, so no frame tears.
- Replaces the fixed 64x128x12 enable-toggled dual RAM with a handshaked, single-clock block.

Parameters:
- PIX_W, 12, pixel width in bits ({b,g,r} 4:4:4 by default).
- COL_W, 7, column address width (128 blocks).
- ROW_W, 6, row address width (64 blocks).
- CLEAR_VAL, 0, pixel value written by the clear sweep (optional feature only).
- Derived: AW = ROW_W+COL_W; DEPTH = 2**AW words per buffer.

Ports:
- clk  in  1  single clock for writer and reader.
- clrn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_col  in  COL_W  write column.
- wr_row  in  ROW_W  write row.
- wr_data  in  PIX_W  write pixel.
- wr_frame_done  in  1  one-cycle pulse: writer finished the back buffer.
- wr_ready  out  1  writes are accepted this cycle.
- rd_en  in  1  read strobe.
- rd_col  in  COL_W  read column.
- rd_row  in  ROW_W  read row.
- rd_frame_start  in  1  one-cycle pulse from VGA at the start of vertical blanking (swap point).
- rd_data  out  PIX_W  read pixel.
- rd_valid  out  1  rd_data holds a valid pixel.
- front_sel  out  1  index of the buffer currently scanned out.
- swap_pulse  out  1  one-cycle pulse when buffers swap.
- drop_cnt  out  16  saturating count of writes rejected because wr_ready=0.
- repeat_cnt  out  16  saturating count of rd_frame_start pulses that caused no swap.

Behaviour:
- Addressing: address = {row, col}, row-major. All codes are in range; there is no bounds check.
- Storage: two DEPTH x PIX_W arrays. Writes target buffer ~front_sel; reads target buffer front_sel. Array contents are not reset.
- Read path: rd_en at cycle N gives rd_data/rd_valid at N+1, from the buffer selected at cycle N.
  - rd_en=0 at N: rd_valid=0 and rd_data=0 at N+1.
  - A read in the same cycle as a swap uses the pre-swap front_sel.
- Write path: a write is accepted iff wr_en && wr_ready, and lands in the back buffer at the clock edge.
  - wr_en && !wr_ready: the write is ignored and drop_cnt increments, saturating at 16'hFFFF.
- State machine:
  - FILL: wr_ready=1.
    - wr_frame_done and rd_frame_start in the same cycle: swap at this edge (toggle front_sel, swap_pulse=1 next cycle), stay in FILL.
    - wr_frame_done alone: go to PENDING.
    - rd_frame_start alone: repeat_cnt++ (saturating), stay in FILL.
  - PENDING: wr_ready=0.
    - rd_frame_start: swap, go to FILL (or CLEAR when enabled).
    - Further wr_frame_done pulses are ignored.
- A write and wr_frame_done in the same cycle in FILL: the write is accepted and belongs to the completed frame.
- swap_pulse is high for exactly the one cycle after the swapping edge; front_sel changes at that edge.
- Reset (asynchronous, any time, including mid-frame or mid-clear):
  - state=FILL, front_sel=0, wr_ready=1, rd_valid=0, rd_data=0, swap_pulse=0, drop_cnt=0, repeat_cnt=0.
  - Any clear sweep is aborted.
- Outputs are registered, except wr_ready, which is decoded from the state register.

Optional Feature:
- Macro: PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN.
- Defined:
  - Every swap enters state CLEAR with wr_ready=0.
  - An internal AW-bit counter writes CLEAR_VAL to the new back buffer at addresses 0..DEPTH-1, one per cycle.
  - After writing address DEPTH-1 the block returns to FILL: exactly DEPTH cycles in CLEAR.
  - Writes during CLEAR are dropped and counted.
  - rd_frame_start during CLEAR increments repeat_cnt.
  - wr_frame_done during CLEAR is ignored.
- Undefined: no CLEAR state, no sweep counter; a swap goes directly to FILL.

Test Plan:
- Reset, write 12'hABC at row 3/col 5, pulse wr_frame_done, then rd_frame_start -> swap_pulse one cycle, front_sel=1. rd_en at row 3/col 5 -> rd_data=12'hABC, rd_valid=1 one cycle later.
- Pulse wr_frame_done, then 3 writes before rd_frame_start -> wr_ready=0, drop_cnt=3, back-buffer contents unchanged.
- Two rd_frame_start pulses with no wr_frame_done -> repeat_cnt=2, front_sel unchanged, no swap_pulse.
- wr_frame_done and rd_frame_start in the same cycle in FILL -> immediate swap, wr_ready stays 1.
- Assert clrn low while in PENDING -> all outputs at reset values immediately (asynchronous); state FILL after release.
- With macro, DEPTH=8192: after a swap, wr_ready=0 for exactly 8192 cycles. After the next swap, every read of the cleared buffer returns CLEAR_VAL unless rewritten.

Source files
------------

// File: rtl/pingpong_framebuf.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_framebuf
// Description : Double-buffered pixel frame store shared by a single-clock
//               writer (ray-tracer host) and reader (VGA scan-out). The writer
//               fills the back buffer while the reader scans the front buffer.
//               Buffers swap only at a reader frame start after the writer has
//               declared its frame done, so scan-out never shows a torn frame.
//
//               Optional build macro PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN:
//               after every swap the new back buffer is swept to CLEAR_VAL,
//               one word per cycle, with writes blocked for DEPTH cycles.
//
// Ports       : clk            - single clock
//               clrn           - asynchronous active-low reset
//               wr_en          - write strobe
//               wr_col/wr_row  - write address ({row,col}, row-major)
//               wr_data        - write pixel
//               wr_frame_done  - pulse: back buffer complete
//               wr_ready       - writes accepted this cycle
//               rd_en          - read strobe
//               rd_col/rd_row  - read address
//               rd_frame_start - pulse: start of vertical blanking (swap point)
//               rd_data        - read pixel (one cycle after rd_en)
//               rd_valid       - rd_data holds a valid pixel
//               front_sel      - index of buffer being scanned out
//               swap_pulse     - one-cycle pulse after a swap
//               drop_cnt       - saturating count of rejected writes
//               repeat_cnt     - saturating count of frame starts without swap
//
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_framebuf #(
    parameter int               PIX_W     = 12,
    parameter int               COL_W     = 7,
    parameter int               ROW_W     = 6,
    parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             wr_frame_done,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    input  logic             rd_frame_start,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             front_sel,
    output logic             swap_pulse,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      repeat_cnt
);

    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
    localparam state_t c_POST_SWAP = ST_CLEAR;
`else
    localparam state_t c_POST_SWAP = ST_FILL;
`endif

    state_t r_state;
    state_t w_next_state;
    logic   w_swap;
    logic   w_repeat_inc;
    logic   w_wr_ready;
    logic   w_wr_accept;

    logic             r_front_sel;
    logic             r_swap_pulse;
    logic [PIX_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [15:0]      r_drop_cnt;
    logic [15:0]      r_repeat_cnt;

    // Both buffers in one array; the MSB of the index selects the buffer.
    logic [PIX_W-1:0] r_mem [0:2*DEPTH-1];

`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
    logic [AW-1:0] r_clr_cnt;
`else
    logic w_unused_clear_val;
    assign w_unused_clear_val = ^CLEAR_VAL;
`endif

    // wr_ready is the only output decoded directly from the state register.
    assign w_wr_ready  = (r_state == ST_FILL);
    assign w_wr_accept = wr_en && w_wr_ready;

    always_comb begin
        w_next_state = r_state;
        w_swap       = 1'b0;
        w_repeat_inc = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (wr_frame_done && rd_frame_start) begin
                    w_swap       = 1'b1;
                    w_next_state = c_POST_SWAP;
                end else if (wr_frame_done) begin
                    w_next_state = ST_PENDING;
                end else if (rd_frame_start) begin
                    w_repeat_inc = 1'b1;
                end
            end
            ST_PENDING: begin
                // Additional wr_frame_done pulses here carry no information.
                if (rd_frame_start) begin
                    w_swap       = 1'b1;
                    w_next_state = c_POST_SWAP;
                end
            end
`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
            ST_CLEAR: begin
                if (rd_frame_start) begin
                    w_repeat_inc = 1'b1;
                end
                if (r_clr_cnt == {AW{1'b1}}) begin
                    w_next_state = ST_FILL;
                end
            end
`endif
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_FILL;
            r_front_sel  <= 1'b0;
            r_swap_pulse <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_drop_cnt   <= '0;
            r_repeat_cnt <= '0;
        end else begin
            r_state      <= w_next_state;
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
            // Uses the pre-swap front_sel, so a read on the swap edge still
            // returns the frame that was being scanned.
            r_rd_valid <= rd_en;
            r_rd_data  <= rd_en ? r_mem[{r_front_sel, rd_row, rd_col}] : '0;
            if (wr_en && !w_wr_ready && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_repeat_inc && (r_repeat_cnt != 16'hFFFF)) begin
                r_repeat_cnt <= r_repeat_cnt + 16'd1;
            end
        end
    end

`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
    // Sweep address restarts at zero on every CLEAR entry because it wraps
    // from all-ones to zero on the final clear cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end else begin
            r_clr_cnt <= '0;
        end
    end
`endif

    // Storage is not reset. Host writes and the clear sweep are mutually
    // exclusive because wr_ready is low throughout CLEAR.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[{~r_front_sel, wr_row, wr_col}] <= wr_data;
        end
`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
        else if (r_state == ST_CLEAR) begin
            r_mem[{~r_front_sel, r_clr_cnt}] <= CLEAR_VAL;
        end
`endif
    end

    assign wr_ready   = w_wr_ready;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign front_sel  = r_front_sel;
    assign swap_pulse = r_swap_pulse;
    assign drop_cnt   = r_drop_cnt;
    assign repeat_cnt = r_repeat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_framebuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_framebuf
// Description : Self-checking bench for pingpong_framebuf. A frame-level
//               reference (two pixel arrays, front index, pending flag and a
//               remaining-clear-cycles count) predicts every output each cycle.
//               Honours PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_framebuf;

    localparam int               PIX_W     = 12;
    localparam int               COL_W     = 7;
    localparam int               ROW_W     = 6;
    localparam int               AW        = ROW_W + COL_W;
    localparam int               DEPTH     = 2 ** AW;
    localparam logic [PIX_W-1:0] CLEAR_VAL = 12'h5A3;
`ifdef PINGPONG_FRAMEBUF_CLEAR_ON_SWAP_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clrn;
    logic             wr_en;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;
    logic [PIX_W-1:0] wr_data;
    logic             wr_frame_done;
    logic             wr_ready;
    logic             rd_en;
    logic [COL_W-1:0] rd_col;
    logic [ROW_W-1:0] rd_row;
    logic             rd_frame_start;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             front_sel;
    logic             swap_pulse;
    logic [15:0]      drop_cnt;
    logic [15:0]      repeat_cnt;

    pingpong_framebuf #(
        .PIX_W     (PIX_W),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clk            (clk),
        .clrn           (clrn),
        .wr_en          (wr_en),
        .wr_col         (wr_col),
        .wr_row         (wr_row),
        .wr_data        (wr_data),
        .wr_frame_done  (wr_frame_done),
        .wr_ready       (wr_ready),
        .rd_en          (rd_en),
        .rd_col         (rd_col),
        .rd_row         (rd_row),
        .rd_frame_start (rd_frame_start),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .front_sel      (front_sel),
        .swap_pulse     (swap_pulse),
        .drop_cnt       (drop_cnt),
        .repeat_cnt     (repeat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [PIX_W-1:0] m_buf   [2][DEPTH];
    bit               m_known [2][DEPTH];
    int               m_front;
    bit               m_pending;
    int               m_clear_left;
    int               m_drop;
    int               m_repeat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_front      = 0;
        m_pending    = 1'b0;
        m_clear_left = 0;
        m_drop       = 0;
        m_repeat     = 0;
    endtask

    task automatic idle();
        wr_en          = 1'b0;
        wr_frame_done  = 1'b0;
        rd_en          = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    // Predict one clock edge from the current inputs, advance, compare.
    task automatic cycle();
        int               wa, ra;
        bit               ready, swap, e_valid, e_known;
        logic [PIX_W-1:0] e_data;
        wa    = int'({wr_row, wr_col});
        ra    = int'({rd_row, rd_col});
        ready = !m_pending && (m_clear_left == 0);

        e_valid = rd_en;
        e_known = rd_en ? m_known[m_front][ra] : 1'b1;
        e_data  = rd_en ? m_buf[m_front][ra] : '0;

        if (wr_en) begin
            if (ready) begin
                m_buf[1-m_front][wa]   = wr_data;
                m_known[1-m_front][wa] = 1'b1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end

        swap = 1'b0;
        if (m_clear_left > 0) begin
            if (rd_frame_start && m_repeat < 65535) m_repeat++;
            m_buf[1-m_front][DEPTH-m_clear_left]   = CLEAR_VAL;
            m_known[1-m_front][DEPTH-m_clear_left] = 1'b1;
            m_clear_left--;
        end else if (m_pending) begin
            if (rd_frame_start) swap = 1'b1;
        end else if (wr_frame_done && rd_frame_start) begin
            swap = 1'b1;
        end else if (wr_frame_done) begin
            m_pending = 1'b1;
        end else if (rd_frame_start && m_repeat < 65535) begin
            m_repeat++;
        end

        if (swap) begin
            m_front      = 1 - m_front;
            m_pending    = 1'b0;
            m_clear_left = CLEAR_EN ? DEPTH : 0;
        end

        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(e_valid));
        if (e_known) check("rd_data", 32'(rd_data), 32'(e_data));
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("swap_pulse", 32'(swap_pulse), 32'(swap));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("repeat_cnt", 32'(repeat_cnt), 32'(m_repeat));
        check("wr_ready", 32'(wr_ready), 32'(!m_pending && m_clear_left == 0));
    endtask

    // Let any clear sweep run out; bounded by the sweep length.
    task automatic wait_ready();
        int n = 0;
        idle();
        while (m_clear_left > 0 && n < DEPTH + 4) begin
            cycle();
            n++;
        end
    endtask

    task automatic do_write(input int row, input int col, input logic [PIX_W-1:0] d);
        idle();
        wr_en   = 1'b1;
        wr_row  = ROW_W'(row);
        wr_col  = COL_W'(col);
        wr_data = d;
        cycle();
        idle();
    endtask

    task automatic do_read(input int row, input int col);
        idle();
        rd_en  = 1'b1;
        rd_row = ROW_W'(row);
        rd_col = COL_W'(col);
        cycle();
        idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_front_sel"}, 32'(front_sel), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_swap_pulse"}, 32'(swap_pulse), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        check({tag, "_repeat_cnt"}, 32'(repeat_cnt), 32'd0);
    endtask

    initial begin
        clrn    = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        rd_row  = '0;
        rd_col  = '0;
        idle();
        model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_known[b][a] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        clrn = 1'b1;
        cycle();

        // Basic write, frame done, swap, read back
        do_write(3, 5, 12'hABC);
        idle(); wr_frame_done = 1'b1; cycle();
        idle(); rd_frame_start = 1'b1; cycle();
        check("swap1_front", 32'(front_sel), 32'd1);
        check("swap1_pulse", 32'(swap_pulse), 32'd1);
        idle(); cycle();
        check("swap1_pulse_off", 32'(swap_pulse), 32'd0);
        wait_ready();
        do_read(3, 5);
        check("read_abc", 32'(rd_data), 32'hABC);
        check("read_abc_valid", 32'(rd_valid), 32'd1);

        // Writes while pending are dropped
        do_write(3, 5, 12'h111);
        idle(); wr_frame_done = 1'b1; cycle();
        for (int i = 0; i < 3; i++) do_write(3, 5, 12'h222 + 12'(i));
        check("pending_ready", 32'(wr_ready), 32'd0);
        check("pending_drop3", 32'(drop_cnt), 32'd3);
        idle(); wr_frame_done = 1'b1; cycle();
        idle(); rd_frame_start = 1'b1; rd_en = 1'b1; rd_row = 6'd3; rd_col = 7'd5; cycle();
        check("swap_read_old_front", 32'(rd_data), 32'hABC);
        wait_ready();
        do_read(3, 5);

        // Two frame starts with no frame done
        for (int i = 0; i < 2; i++) begin
            idle(); rd_frame_start = 1'b1; cycle();
            idle(); cycle();
        end
        check("repeat2", 32'(repeat_cnt), 32'd2);

        // Simultaneous done and start in FILL
        do_write(1, 2, 12'h0F0);
        idle(); wr_en = 1'b1; wr_row = 6'd1; wr_col = 7'd3; wr_data = 12'h00F;
        wr_frame_done = 1'b1; rd_frame_start = 1'b1; cycle();
        wait_ready();
        do_read(1, 2);
        do_read(1, 3);

        // Asynchronous reset while pending
        idle(); wr_frame_done = 1'b1; cycle();
        idle();
        check("pre_async_ready", 32'(wr_ready), 32'd0);
        #2;
        clrn = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        clrn = 1'b1;
        model_reset();
        cycle();

        // Randomized traffic over a small window so reads hit written pixels
        for (int i = 0; i < 3000; i++) begin
            wr_en          = ($urandom_range(0, 1) == 1);
            wr_row         = ROW_W'($urandom_range(0, 3));
            wr_col         = COL_W'($urandom_range(0, 7));
            wr_data        = PIX_W'($urandom);
            wr_frame_done  = ($urandom_range(0, 31) == 0);
            rd_en          = ($urandom_range(0, 1) == 1);
            rd_row         = ROW_W'($urandom_range(0, 3));
            rd_col         = COL_W'($urandom_range(0, 7));
            rd_frame_start = ($urandom_range(0, 24) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
